// File: rtl/fact_pkg.sv
// Shared encodings for the gen2 factorial peripheral: FSM states, word addresses
// and STATUS bit positions.
package fact_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MULT = 2'd2
    } fact_state_t;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_BUSY = 2;

endpackage

// File: rtl/fact_mul_ovf.sv
// Combinational prod*cnt step: low half of the double-width product plus a flag
// raised when the upper half is nonzero (the result no longer fits).
module fact_mul_ovf #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] prod,
    input  logic [N_WIDTH-1:0]    cnt,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  ovf
);

    logic [2*DATA_WIDTH-1:0] full;

    assign full = (2*DATA_WIDTH)'(prod) * (2*DATA_WIDTH)'(cnt);
    assign lo   = full[DATA_WIDTH-1:0];
    assign ovf  = |full[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/fact_accel_gen2.sv
// Memory-mapped iterative factorial accelerator (gen2): register file, control FSM
// and combinational read mux.
module fact_accel_gen2
    import fact_pkg::*;
#(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            A,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  done_pls
);

    fact_state_t           state, state_nxt;
    logic [N_WIDTH-1:0]    n_reg;
    logic [N_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] result;
    logic                  done, err, busy;

    logic [DATA_WIDTH-1:0] mul_lo;
    logic                  mul_ovf;
    logic                  go_acc, load, mult_step, fin_ok, fin_ovf;

    // Only WD[N_WIDTH-1:0] and WD[0] carry meaning; the rest is deliberately dropped.
    logic unused_wd;
    assign unused_wd = ^WD[DATA_WIDTH-1:N_WIDTH];

    fact_mul_ovf #(
        .N_WIDTH    (N_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .prod (prod),
        .cnt  (cnt),
        .lo   (mul_lo),
        .ovf  (mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_acc    = 1'b0;
        load      = 1'b0;
        mult_step = 1'b0;
        fin_ok    = 1'b0;
        fin_ovf   = 1'b0;
        case (state)
            S_IDLE: begin
                if (WE && (A == ADDR_CTRL) && WD[0]) begin
                    go_acc    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load      = 1'b1;
                state_nxt = S_MULT;
            end
            S_MULT: begin
                // n=0 and n=1 both terminate here on the first MULT cycle with prod=1.
                if (cnt <= N_WIDTH'(1)) begin
                    fin_ok    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (mul_ovf) begin
                    fin_ovf   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    mult_step = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg    <= '0;
            cnt      <= '0;
            prod     <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done_pls <= 1'b0;
        end else begin
            done_pls <= 1'b0;
            if (WE && (A == ADDR_N)) n_reg <= WD[N_WIDTH-1:0];
            if (go_acc) begin
                done <= 1'b0;
                err  <= 1'b0;
                busy <= 1'b1;
            end
            if (load) begin
                prod <= DATA_WIDTH'(1);
                cnt  <= n_reg;
            end
            if (mult_step) begin
                prod <= mul_lo;
                cnt  <= cnt - N_WIDTH'(1);
            end
            if (fin_ok || fin_ovf) begin
                result   <= fin_ok ? prod : '0;
                err      <= fin_ovf;
                done     <= 1'b1;
                done_pls <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            ADDR_N:      RD[N_WIDTH-1:0] = n_reg;
            ADDR_CTRL:   RD[0] = busy;
            ADDR_STATUS: begin
                RD[ST_BUSY] = busy;
                RD[ST_ERR]  = err;
                RD[ST_DONE] = done;
            end
            default:     RD = result;
        endcase
    end

endmodule
